// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: request/response and RAM-port bundle shared by bram_port_arbiter and its users
// Ports (all in the bundle):
//   req0_*/req1_* : valid/we/addr/wdata from the requesters; ready back to them
//   rsp0_*/rsp1_* : one-cycle read-data pulses to the requesters
//   bram_*        : address/data/write-enable to the RAM port, dout back from it
// slave modport is the arbiter side; master modport is the requester/RAM side.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, rsp0_rdata;
  logic                  req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata, rsp1_rdata;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din, bram_dout;
  logic                  bram_we;
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  bram_dout,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output bram_addr, bram_din, bram_we
  );
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output bram_dout,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  bram_addr, bram_din, bram_we
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one RAM port between two valid/ready requesters
// Ports:
//   clk   : single clock for the block and the RAM port it drives
//   rst_n : asynchronous active-low reset
//   bus   : bram_port_arbiter_if.slave (requests, read responses, RAM port)
// Reads return exactly 4 cycles after acceptance: 1 issue register + 2 RAM cycles + 1 response register.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  bram_port_arbiter_if.slave bus
);
  logic                  ptr, gnt_v, gnt_id, acc, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            tv, tid;
  // ptr names the requester that wins when both are valid
  always_comb begin
    gnt_v     = bus.req0_valid | bus.req1_valid;
    gnt_id    = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
    acc       = rst_n & gnt_v;
    sel_we    = gnt_id ? bus.req1_we : bus.req0_we;
    sel_addr  = gnt_id ? bus.req1_addr : bus.req0_addr;
    sel_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;
  end
  // ready is gated by rst_n so nothing is offered while reset is held
  assign bus.req0_ready = acc & ~gnt_id;
  assign bus.req1_ready = acc & gnt_id;
  // tag stage 4 (index 3) lines up with the registered read data
  assign bus.rsp0_valid = tv[3] & ~tid[3];
  assign bus.rsp1_valid = tv[3] & tid[3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= '0;
      bus.bram_we    <= 1'b0;
      tv             <= '0;
      tid            <= '0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
    end else begin
      if (acc) begin
        ptr           <= ~gnt_id;
        bus.bram_addr <= sel_addr;
        bus.bram_din  <= sel_wdata;
      end
      bus.bram_we <= acc & sel_we;
      tv          <= {tv[2:0], acc & ~sel_we};
      tid         <= {tid[2:0], gnt_id};
      // stage 3 is the cycle bram_dout carries the read; capture it for the owner only
      if (tv[2] & ~tid[2]) bus.rsp0_rdata <= bus.bram_dout;
      if (tv[2] & tid[2]) bus.rsp1_rdata <= bus.bram_dout;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed self-checking bench for bram_port_arbiter with a 2-cycle RAM model
module tb_bram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] r1;
  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
    r1 <= mem[bus.bram_addr];
    bus.bram_dout <= r1;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int q_cyc[$];
  bit q_id[$];
  logic [DW-1:0] q_dat[$];
  int we_cnt = 0;
  always @(negedge clk) begin
    if (bus.rsp0_valid) begin q_cyc.push_back(cyc); q_id.push_back(1'b0); q_dat.push_back(bus.rsp0_rdata); end
    if (bus.rsp1_valid) begin q_cyc.push_back(cyc); q_id.push_back(1'b1); q_dat.push_back(bus.rsp1_rdata); end
    if (bus.bram_we) we_cnt <= we_cnt + 1;
  end
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_rsp(input string tag, input int i, input int c, input bit id, input logic [DW-1:0] d);
    chk({tag, "_cyc"}, i < q_cyc.size() ? q_cyc[i] : -1, c);
    chk({tag, "_id"}, i < q_id.size() ? 32'(q_id[i]) : 32'hFFFF_FFFF, 32'(id));
    chk({tag, "_dat"}, i < q_dat.size() ? 32'(q_dat[i]) : 32'hFFFF_FFFF, 32'(d));
  endtask
  task automatic drive(input bit id, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; end
    else begin bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; end
  endtask
  task automatic issue(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
    drive(id, 1'b1, we, a, d);
    n = -1;
    for (int k = 0; k < 8 && n < 0; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) n = cyc;
      @(posedge clk);
      #1;
    end
    drive(id, 1'b0, 1'b0, '0, '0);
    chk("accept", 32'(n >= 0), 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  int n, s, qb, w0, i0, i1;
  int acc1[4];
  initial begin
    drive(0, 1'b1, 1'b0, 10'h5, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp0_rdata", bus.rsp0_rdata, 0);
    chk("rst_bram_we", bus.bram_we, 0);
    chk("rst_bram_addr", bus.bram_addr, 0);
    chk("rst_bram_din", bus.bram_din, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) issue(0, 1'b1, AW'(i), 16'hA000 + 16'(i), n);
    issue(0, 1'b1, 10'h1, 16'h1111, n);
    issue(0, 1'b1, 10'h2, 16'h2222, n);
    issue(0, 1'b1, 10'h5, 16'hBEEF, n);
    repeat (4) @(posedge clk);
    #1;
    qb = q_cyc.size();
    issue(0, 1'b0, 10'h5, '0, n);
    @(negedge clk);
    chk("t1_bram_addr", bus.bram_addr, 10'h5);
    chk("t1_bram_we", bus.bram_we, 0);
    repeat (6) @(posedge clk);
    chk("t1_nrsp", q_cyc.size() - qb, 1);
    chk_rsp("t1", qb, n + 4, 1'b0, 16'hBEEF);
    chk("t1_hold", bus.rsp0_rdata, 16'hBEEF);
    do_reset();
    qb = q_cyc.size();
    drive(0, 1'b1, 1'b0, 10'h1, '0);
    drive(1, 1'b1, 1'b0, 10'h2, '0);
    s = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      chk("t2_ready0", bus.req0_ready, 32'(k % 2 == 0));
      chk("t2_ready1", bus.req1_ready, 32'(k % 2 == 1));
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (7) @(posedge clk);
    chk("t2_nrsp", q_cyc.size() - qb, 4);
    for (int k = 0; k < 4; k++)
      chk_rsp("t2", qb + k, s + 4 + k, 1'(k % 2), (k % 2 == 1) ? 16'h2222 : 16'h1111);
    #1;
    qb = q_cyc.size();
    w0 = we_cnt;
    drive(1, 1'b1, 1'b1, 10'h3FF, 16'h1234);
    @(negedge clk);
    chk("t3_wr_ready", bus.req1_ready, 1);
    s = cyc;
    @(posedge clk);
    #1 drive(1, 1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    chk("t3_rd_ready", bus.req1_ready, 1);
    chk("t3_we", bus.bram_we, 1);
    chk("t3_addr", bus.bram_addr, 10'h3FF);
    chk("t3_din", bus.bram_din, 16'h1234);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t3_we_drop", bus.bram_we, 0);
    chk("t3_addr_keep", bus.bram_addr, 10'h3FF);
    repeat (6) @(posedge clk);
    chk("t3_we_pulses", we_cnt - w0, 1);
    chk("t3_nrsp", q_cyc.size() - qb, 1);
    chk_rsp("t3", qb, s + 5, 1'b1, 16'h1234);
    #1;
    qb = q_cyc.size();
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, i0 < 4, 1'b1, AW'(i0), 16'hB000 + 16'(i0));
      drive(1, i1 < 4, 1'b0, AW'(i1), '0);
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) i0++;
      if (bus.req1_valid && bus.req1_ready) begin acc1[i1] = cyc; i1++; end
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (7) @(posedge clk);
    chk("t4_writes", i0, 4);
    chk("t4_reads", i1, 4);
    chk("t4_nrsp", q_cyc.size() - qb, 4);
    for (int j = 0; j < 4; j++) chk_rsp("t4", qb + j, acc1[j] + 4, 1'b1, 16'hB000 + 16'(j));
    #1;
    issue(0, 1'b0, 10'h5, '0, n);
    qb = q_cyc.size();
    @(posedge clk);
    #1 rst_n = 0;
    drive(1, 1'b1, 1'b0, 10'h2, '0);
    @(negedge clk);
    chk("t5_ready0", bus.req0_ready, 0);
    chk("t5_ready1", bus.req1_ready, 0);
    chk("t5_we", bus.bram_we, 0);
    chk("t5_addr", bus.bram_addr, 0);
    chk("t5_din", bus.bram_din, 0);
    chk("t5_rdata1", bus.rsp1_rdata, 0);
    chk("t5_rvalid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(0, 1'b1, 1'b0, 10'h5, '0);
    @(negedge clk);
    s = cyc;
    chk("t5_ptr_ready0", bus.req0_ready, 1);
    chk("t5_ptr_ready1", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (7) @(posedge clk);
    chk("t5_nrsp", q_cyc.size() - qb, 1);
    chk_rsp("t5", qb, s + 4, 1'b0, 16'hBEEF);
    do_reset();
    drive(0, 1'b1, 1'b0, 10'h5, '0);
    drive(1, 1'b1, 1'b0, 10'h1, '0);
    @(negedge clk);
    chk("t6_ready0", bus.req0_ready, 1);
    chk("t6_ready1", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t6_idle_ready1", bus.req1_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 10'h5, '0);
    drive(1, 1'b1, 1'b0, 10'h1, '0);
    @(negedge clk);
    chk("t6_ptr_ready1", bus.req1_ready, 1);
    chk("t6_ptr_ready0", bus.req0_ready, 0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (6) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
